// File: rtl/fetch_buffer.sv
// fetch_buffer
//
// Instruction fetch buffer placed right after the PC stage. Every cycle the
// incoming PC is driven straight to the synchronous instruction memory. When
// a fetch is issued, the PC is remembered alongside a valid flag so that the
// memory's read data can be paired with it one cycle later. The data and PC
// are then queued in a small FIFO for decode.
//
// The buffer back-pressures the PC stage through stall_o. A branch flushes
// all queued entries and discards the fetch that is still in flight.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high; clears the pointers, the count and
//                the in-flight request (the FIFO storage is left as is)
//   pc_i         current PC from the PC stage
//   stall_o      to the PC stage: hold the PC, no fetch issued this cycle
//   branch_i     redirect/flush; discards queued and in-flight fetches
//   imem_addr_o  instruction-memory read address (equals pc_i)
//   imem_data_i  read data for the address issued in the previous cycle
//   stall_i      from decode: head entry not consumed this cycle
//   valid_o      head entry valid
//   inst_o       head instruction; 0 when the FIFO is empty
//   inst_pc_o    PC of the head instruction; 0 when the FIFO is empty

module fetch_buffer #(
    parameter int ADDR  = 32,
    parameter int INST  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ADDR-1:0] pc_i,
    output logic            stall_o,
    input  logic            branch_i,
    output logic [ADDR-1:0] imem_addr_o,
    input  logic [INST-1:0] imem_data_i,
    input  logic            stall_i,
    output logic            valid_o,
    output logic [INST-1:0] inst_o,
    output logic [ADDR-1:0] inst_pc_o
);

    localparam int PW = $clog2(DEPTH);

    // FIFO storage, kept as two parallel arrays indexed by the same pointer
    logic [INST-1:0] inst_mem_q [DEPTH];
    logic [ADDR-1:0] pc_mem_q   [DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            req_valid_q, req_valid_d;
    logic [ADDR-1:0] req_pc_q, req_pc_d;

    logic [PW+1:0]   occupancy;
    logic            issue;
    logic            push;
    logic            pop;

    // The in-flight request counts as occupied, so a slot is always free for
    // its data when it returns. No credit is given for a pop in this cycle,
    // which keeps stall_o a function of registers only.
    assign occupancy   = {1'b0, count_q} + {{(PW+1){1'b0}}, req_valid_q};
    assign stall_o     = occupancy >= (PW+2)'(DEPTH);
    assign imem_addr_o = pc_i;

    assign issue = ~stall_o & ~branch_i;
    // Reset is folded in so that the returning data is never written while
    // the buffer is being cleared.
    assign push  = req_valid_q & ~branch_i & ~reset;
    assign pop   = valid_o & ~stall_i & ~branch_i;

    assign valid_o   = (count_q != '0);
    assign inst_o    = valid_o ? inst_mem_q[rd_ptr_q] : '0;
    assign inst_pc_o = valid_o ? pc_mem_q[rd_ptr_q]   : '0;

    // Next-state logic. A branch overrides every other update: the FIFO is
    // emptied and the pending response is dropped.
    always_comb begin
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        wr_ptr_d    = wr_ptr_q + PW'(push);
        count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
        req_valid_d = issue;
        req_pc_d    = issue ? pc_i : req_pc_q;
        if (branch_i) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            req_valid_d = 1'b0;
        end
    end

    // Control state, with reset taking priority over everything else
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    // FIFO storage has no reset; entries are only visible through the count
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_data_i;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
//
// Bench for fetch_buffer. The instruction memory is modelled as a hash of
// the address, so the expected instruction of any queued PC is known.
// A queue-based reference model tracks what decode should see.

module tb_fetch_buffer;

    localparam int ADDR  = 32;
    localparam int INST  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [ADDR-1:0] pc_i;
    logic            stall_o;
    logic            branch_i;
    logic [ADDR-1:0] imem_addr_o;
    logic [INST-1:0] imem_data_i;
    logic            stall_i;
    logic            valid_o;
    logic [INST-1:0] inst_o;
    logic [ADDR-1:0] inst_pc_o;

    fetch_buffer #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_i       (pc_i),
        .stall_o    (stall_o),
        .branch_i   (branch_i),
        .imem_addr_o(imem_addr_o),
        .imem_data_i(imem_data_i),
        .stall_i    (stall_i),
        .valid_o    (valid_o),
        .inst_o     (inst_o),
        .inst_pc_o  (inst_pc_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued PCs in decode order plus the pending request
    logic [ADDR-1:0] mQueue[$];
    bit              mInflight = 1'b0;
    logic [ADDR-1:0] mInflightPc = '0;
    bit              modelOn = 1'b0;

    typedef struct {
        logic        rst;
        logic        br;
        logic        stl;
        logic [31:0] pc;
        logic        chk;
        logic        expValid;
        logic [31:0] expPc;
        logic        expStall;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit modelStall();
        return (mQueue.size() + (mInflight ? 1 : 0)) >= DEPTH;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output with the reference model
    task automatic checkOutput();
        logic        expValid;
        logic [31:0] expPc;
        expValid = (mQueue.size() != 0);
        expPc    = expValid ? mQueue[0] : 32'h0;
        checkValue("model.valid", {31'b0, valid_o}, {31'b0, expValid});
        checkValue("model.inst_pc", inst_pc_o, expPc);
        checkValue("model.inst", inst_o, expValid ? memWord(expPc) : 32'h0);
        checkValue("model.stall", {31'b0, stall_o}, {31'b0, modelStall()});
        checkValue("model.imem_addr", imem_addr_o, pc_i);
    endtask

    // Advance the model by one clock using the inputs applied this cycle
    task automatic modelStep();
        bit stallNow;
        stallNow = modelStall();
        if (reset || branch_i) begin
            mQueue.delete();
            mInflight = 1'b0;
        end else begin
            if (mQueue.size() != 0 && !stall_i) void'(mQueue.pop_front());
            if (mInflight) mQueue.push_back(mInflightPc);
            mInflight   = !stallNow;
            mInflightPc = pc_i;
        end
    endtask

    // Drive one cycle of inputs; memory returns data only for a real request
    task automatic applyStimulus(input logic rst, input logic br, input logic stl, input logic [31:0] pc);
        reset       = rst;
        branch_i    = br;
        stall_i     = stl;
        pc_i        = pc;
        imem_data_i = mInflight ? memWord(mInflightPc) : $urandom;
        @(negedge clk);
        if (modelOn) checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic addVec(input logic rst, input logic br, input logic stl, input logic [31:0] pc,
                          input logic chk, input logic ev, input logic [31:0] ep, input logic es);
        vec_t v;
        v.rst = rst; v.br = br; v.stl = stl; v.pc = pc;
        v.chk = chk; v.expValid = ev; v.expPc = ep; v.expStall = es;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] pc;
        bit          rst;
        bit          br;
        bit          stl;
        bit          issued;

        reset = 1'b1; branch_i = 1'b0; stall_i = 1'b0; pc_i = '0; imem_data_i = '0;

        // ---------------- table-driven vectors ----------------
        addVec(1, 0, 0, 0, 0, 0, 0, 0);
        // streaming with decode always ready
        for (int k = 0; k < 6; k++)
            addVec(0, 0, 0, k, 1, k >= 2, (k >= 2) ? k - 2 : 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0);
        // decode stalled: fill to capacity, PC stage holds once stalled
        for (int k = 0; k < 7; k++)
            addVec(0, 0, 1, (k < 4) ? k : 4, 1, k >= 2, 0, k >= 4);
        // single-cycle release, then refill
        addVec(0, 0, 0, 4, 1, 1, 0, 1);
        addVec(0, 0, 1, 4, 1, 1, 1, 0);
        addVec(0, 0, 1, 5, 1, 1, 1, 1);
        addVec(0, 0, 1, 5, 1, 1, 1, 1);
        // drain and check ordering
        addVec(0, 0, 0, 5, 1, 1, 1, 1);
        addVec(0, 0, 0, 5, 1, 1, 2, 0);
        addVec(0, 0, 0, 6, 1, 1, 3, 0);
        addVec(0, 0, 0, 7, 1, 1, 4, 0);
        addVec(0, 0, 0, 8, 1, 1, 5, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].br, vecs[i].stl, vecs[i].pc);
            if (vecs[i].chk) begin
                checkValue("tbl.valid", {31'b0, valid_o}, {31'b0, vecs[i].expValid});
                checkValue("tbl.inst_pc", inst_pc_o, vecs[i].expValid ? vecs[i].expPc : 32'h0);
                checkValue("tbl.inst", inst_o, vecs[i].expValid ? memWord(vecs[i].expPc) : 32'h0);
                checkValue("tbl.stall", {31'b0, stall_o}, {31'b0, vecs[i].expStall});
            end
            endCycle();
            modelOn = 1'b1;
        end

        // ---------------- branch with 3 queued + 1 in flight ----------------
        applyStimulus(1, 0, 1, 0); endCycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, k); endCycle();
        end
        applyStimulus(0, 1, 1, 32'h40);
        checkValue("br.valid_before", {31'b0, valid_o}, 32'd1);
        endCycle();
        applyStimulus(0, 0, 0, 32'h40);
        checkValue("br.valid_n1", {31'b0, valid_o}, 32'd0);
        checkValue("br.stall_n1", {31'b0, stall_o}, 32'd0);
        endCycle();
        applyStimulus(0, 0, 0, 32'h44);
        checkValue("br.valid_n2", {31'b0, valid_o}, 32'd0);
        endCycle();
        applyStimulus(0, 0, 0, 32'h48);
        checkValue("br.valid_n3", {31'b0, valid_o}, 32'd1);
        checkValue("br.pc_n3", inst_pc_o, 32'h40);
        checkValue("br.inst_n3", inst_o, memWord(32'h40));
        endCycle();

        // ---------------- reset mid-stream with 2 queued ----------------
        applyStimulus(1, 0, 1, 0); endCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, k); endCycle();
        end
        applyStimulus(1, 0, 1, 3);
        checkValue("rst.pc_before", inst_pc_o, 32'h0);
        endCycle();
        applyStimulus(0, 0, 0, 7);
        checkValue("rst.valid", {31'b0, valid_o}, 32'd0);
        checkValue("rst.inst", inst_o, 32'h0);
        checkValue("rst.stall", {31'b0, stall_o}, 32'd0);
        endCycle();
        applyStimulus(0, 0, 0, 8); endCycle();
        applyStimulus(0, 0, 0, 9);
        checkValue("rst.refill_pc", inst_pc_o, 32'h7);
        endCycle();

        // ---------------- push+pop at DEPTH-1 with write-pointer wrap ----------------
        applyStimulus(1, 0, 1, 0); endCycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, k); endCycle();
        end
        applyStimulus(0, 0, 0, 4);
        checkValue("wrap.stall", {31'b0, stall_o}, 32'd1);
        checkValue("wrap.head0", inst_pc_o, 32'h0);
        endCycle();
        applyStimulus(0, 0, 0, 4);
        checkValue("wrap.stall_after", {31'b0, stall_o}, 32'd0);
        checkValue("wrap.head1", inst_pc_o, 32'h1);
        endCycle();
        for (int k = 2; k < 5; k++) begin
            applyStimulus(0, 0, 0, k + 3);
            checkValue("wrap.order", inst_pc_o, k);
            checkValue("wrap.inst", inst_o, memWord(k));
            endCycle();
        end

        // ---------------- randomized traffic against the model ----------------
        applyStimulus(1, 0, 0, 0); endCycle();
        pc = 32'h100;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            br  = ($urandom_range(0, 99) < 5);
            stl = ($urandom_range(0, 99) < 40);
            issued = !rst && !br && !modelStall();
            applyStimulus(rst, br, stl, pc);
            endCycle();
            if (br)          pc = $urandom & 32'hFFFF_FFFC;
            else if (issued) pc = pc + 32'd4;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
